// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO, with MFHI/MFLO/MTHI/MTLO service and EX stall.
// Optional: define MDU_DIVZERO_FLAG_EN to add a registered DivZero pulse output.
module mdu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Valid,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiLoOut,
  output logic [WIDTH-1:0] Hi,
`ifdef MDU_DIVZERO_FLAG_EN
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero
`else
  output logic [WIDTH-1:0] Lo
`endif
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_a, neg_b, op_div, b_zero;

  logic is_hilo, is_muldiv, accept, sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    is_muldiv = (Funct == F_MULT) || (Funct == F_MULTU) ||
                (Funct == F_DIV)  || (Funct == F_DIVU);
    is_hilo   = is_muldiv || (Funct == F_MFHI) || (Funct == F_MTHI) ||
                (Funct == F_MFLO) || (Funct == F_MTLO);
    Stall     = Valid && is_hilo && (Busy || (state != IDLE));
    accept    = (state == IDLE) && Valid && is_muldiv && !Stall;
    sgn       = !Funct[0];
    mag_a     = (sgn && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
    mag_b     = (sgn && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;

    HiLoOut = '0;
    if (Valid && Funct == F_MFHI) HiLoOut = Hi;
    if (Valid && Funct == F_MFLO) HiLoOut = Lo;
  end

  // acc holds {partial product} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_step = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quot_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = Funct[1] ? DIV : MUL;
      MUL,
      DIV:     if (cnt == LAST) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      Hi     <= '0;
      Lo     <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      op_div <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
      Done  <= (state == FIXUP);
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            neg_a  <= sgn && Rdata1[WIDTH-1];
            neg_b  <= sgn && Rdata2[WIDTH-1];
            op_div <= Funct[1];
            b_zero <= (Rdata2 == '0);
            opnd   <= Funct[1] ? mag_b : mag_a;
            acc    <= {{WIDTH{1'b0}}, (Funct[1] ? mag_a : mag_b)};
          end else if (Valid && Funct == F_MTHI) begin
            Hi <= Rdata1;
          end else if (Valid && Funct == F_MTLO) begin
            Lo <= Rdata1;
          end
        end
        MUL: begin
          acc <= mul_step;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_step;
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          if (!op_div) begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            // remainder holds |dividend|; restoring the sign recovers the original Rdata1
            Hi <= rem_fix;
            Lo <= '1;
          end else begin
            Hi <= rem_fix;
            Lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_DIVZERO_FLAG_EN
  always_ff @(posedge CLK) begin
    if (RST) DivZero <= 1'b0;
    else     DivZero <= (state == FIXUP) && op_div && b_zero;
  end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table through a HI/LO scoreboard plus stall/MT/reset sequences.
module tb_mdu_ctrl;
  localparam int unsigned W = 32;

  logic          CLK = 1'b0;
  logic          RST, Valid;
  logic [5:0]    Funct;
  logic [W-1:0]  Rdata1, Rdata2;
  logic          Stall, Busy, Done;
  logic [W-1:0]  HiLoOut, Hi, Lo;
`ifdef MDU_DIVZERO_FLAG_EN
  logic          DivZero;
`endif

  mdu_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Valid(Valid), .Funct(Funct),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Stall(Stall), .Busy(Busy),
    .Done(Done), .HiLoOut(HiLoOut), .Hi(Hi),
`ifdef MDU_DIVZERO_FLAG_EN
    .Lo(Lo), .DivZero(DivZero)
`else
    .Lo(Lo)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]   f;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi, lo;
    logic         dz;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    exp_t e;
    int   busy_cnt = 0;
    bit   got = 0;
    @(negedge CLK);
    Valid = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
    e.hi = hi; e.lo = lo; e.dz = dz;
    sb.push_back(e);
    @(negedge CLK);
    Valid = 1'b0; Rdata1 = $urandom; Rdata2 = $urandom;
    for (int i = 0; i < 100; i++) begin
      if (Done) begin got = 1; break; end
      if (Busy) busy_cnt++;
      @(negedge CLK);
    end
    check("done_seen", W'(got), 1);
    check("busy_cycles", W'(busy_cnt), 33);
    e = sb.pop_front();
    check("hi", Hi, e.hi);
    check("lo", Lo, e.lo);
`ifdef MDU_DIVZERO_FLAG_EN
    check("divzero", W'(DivZero), W'(e.dz));
`endif
    @(negedge CLK);
    check("done_pulse_end", W'(Done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   stall_cnt, done_cnt;

    vecs[0]  = '{6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[2]  = '{6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{6'h1A, 32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{6'h1B, 32'hFFFFFFFF, 32'd3,        32'h00000000, 32'h55555555, 1'b0};
    vecs[7]  = '{6'h1A, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0};
    vecs[8]  = '{6'h19, 32'h12345678, 32'h00000064, 32'h00000007, 32'h1C71C6E0, 1'b0};
    vecs[9]  = '{6'h1A, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{6'h1A, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

    RST = 1'b1; Valid = 1'b0; Funct = '0; Rdata1 = '0; Rdata2 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_hi", Hi, 0);
    check("rst_lo", Lo, 0);
    check("rst_busy", W'(Busy), 0);
    check("rst_done", W'(Done), 0);
    check("rst_stall", W'(Stall), 0);
    RST = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // MULTU followed immediately by a stalled MFLO
    @(negedge CLK);
    Valid = 1'b1; Funct = 6'h19; Rdata1 = '1; Rdata2 = '1;
    e.hi = 32'hFFFFFFFE; e.lo = 32'h00000001; e.dz = 1'b0;
    sb.push_back(e);
    @(negedge CLK);
    Funct = 6'h12; Rdata1 = '0; Rdata2 = '0;
    stall_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!Stall) break;
      stall_cnt++;
      @(negedge CLK);
    end
    e = sb.pop_front();
    check("mflo_stall_cycles", W'(stall_cnt), 33);
    check("mflo_done_cycle", W'(Done), 1);
    check("mflo_value", HiLoOut, e.lo);
    @(negedge CLK);
    Funct = 6'h10;
    #1;
    check("mfhi_nostall", W'(Stall), 0);
    check("mfhi_value", HiLoOut, e.hi);
    Valid = 1'b0;
    #1;
    check("hilo_idle_zero", HiLoOut, 0);

    // MTHI / MTLO / MFHI back to back
    @(negedge CLK);
    Valid = 1'b1; Funct = 6'h11; Rdata1 = 32'hA5A5A5A5;
    #1 check("mthi_nostall", W'(Stall), 0);
    @(negedge CLK);
    Funct = 6'h13; Rdata1 = 32'h5A5A5A5A;
    #1 check("mtlo_nostall", W'(Stall), 0);
    @(negedge CLK);
    Funct = 6'h10; Rdata1 = '0;
    #1;
    check("mt_mfhi_nostall", W'(Stall), 0);
    check("mt_mfhi_value", HiLoOut, 32'hA5A5A5A5);
    check("mt_lo_reg", Lo, 32'h5A5A5A5A);
    check("mt_hi_reg", Hi, 32'hA5A5A5A5);

    // Abort an in-flight MULT with reset, then re-issue it
    @(negedge CLK);
    Funct = 6'h18; Rdata1 = 32'd7; Rdata2 = 32'd9;
    @(negedge CLK);
    Valid = 1'b0;
    repeat (9) @(negedge CLK);
    Valid = 1'b1; Funct = 6'h20;
    #1 check("other_funct_nostall", W'(Stall), 0);
    Funct = 6'h11;
    #1 check("mthi_busy_stall", W'(Stall), 1);
    Valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", W'(Busy), 0);
    check("abort_hi", Hi, 0);
    check("abort_lo", Lo, 0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) done_cnt++;
      @(negedge CLK);
    end
    check("abort_no_done", W'(done_cnt), 0);
    run_op(6'h18, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the EX stage.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs an iterative shift-add multiply or restoring divide.
- Serves MFHI/MFLO/MTHI/MTLO.
- Stalls the pipeline whenever a HI/LO instruction collides with an operation still in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- Valid  in  1  EX holds a valid R-type instruction this cycle (Opcode==0).
- Funct  in  6  Ins[5:0].
- Rdata1  in  WIDTH  rs value (multiplicand / dividend / MTHI/MTLO source).
- Rdata2  in  WIDTH  rt value (multiplier / divisor).
- Stall  out  1  combinational; freeze IF/ID/EX this cycle.
- Busy  out  1  registered; iterative operation in flight.
- Done  out  1  registered one-cycle pulse after HI/LO written by mult/div.
- HiLoOut  out  WIDTH  combinational; HI for MFHI, LO for MFLO, else 0.
- Hi  out  WIDTH  current HI register.
- Lo  out  WIDTH  current LO register.

Behaviour:
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - All other codes are ignored: no stall, no state change.
- Reset: state=IDLE; Hi=Lo=0; Busy=0; Done=0; iteration counter=0.
  - Reset mid-operation aborts it. The partial result is discarded and HI/LO read 0 next cycle.
- States: IDLE, MUL, DIV, FIXUP.
- Accept:
  - Condition: in IDLE with Valid and a mult/div Funct, Stall=0.
  - Next edge: latch |operands| and the sign flags (signed ops only); counter=0; go to MUL or DIV; Busy=1.
- MUL: one shift-add step per cycle over a 2*WIDTH product. After WIDTH cycles go to FIXUP.
- DIV: one restoring step per cycle (shift remainder, trial subtract, quotient bit). After WIDTH cycles go to FIXUP.
- FIXUP: one cycle.
  - Apply sign correction:
    - Product negated if the operand signs differ.
    - Quotient negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Write HI/LO at the edge ending FIXUP:
    - Mult: HI=product[2W-1:W], LO=product[W-1:0].
    - Div: HI=remainder, LO=quotient.
  - Go to IDLE, Busy=0, Done=1 for exactly the next cycle.
- Latency: accept edge plus WIDTH+1 cycles until HI/LO are valid. Busy is high for exactly WIDTH+1 cycles (33 at default).
- Stall=1 iff Valid && Funct is any of the 8 HI/LO ops && (Busy || state!=IDLE).
  - A stalled instruction is re-presented each cycle and is accepted or served on the first cycle Busy=0.
  - No stall for the Done cycle.
- MFHI/MFLO when not busy: HiLoOut returns the register value in the same cycle. A value written at the FIXUP edge is visible the next cycle.
- MTHI/MTLO when not busy: register written from Rdata1 at the next edge; the other register is unchanged.
- Divide by zero (Rdata2==0): takes the full WIDTH+1 cycles, skips sign correction. Result: HI=Rdata1 (original), LO=all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no exception).
- Operands are latched at accept. Later changes on Rdata1/Rdata2 during Busy have no effect.

Optional Feature:
- Macro: MDU_DIVZERO_FLAG_EN.
- Defined: adds output port DivZero (1 bit, registered, reset 0). DivZero pulses high in the same cycle as Done for DIV/DIVU with divisor 0.
- Undefined: no port, no logic; the divide-by-zero result is unchanged.

Test Plan:
- MULT Rdata1=0xFFFFFFFD (-3), Rdata2=5 -> Busy high 33 cycles, then Done; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 100/7 -> HI=2, LO=14. Then DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MULTU 0xFFFFFFFF*0xFFFFFFFF, then MFLO presented on the next cycle -> Stall=1 for 33 cycles; then HiLoOut=0x00000001. MFHI afterwards -> 0xFFFFFFFE with no stall.
- DIV 1234/0 -> HI=1234, LO=0xFFFFFFFF; with MDU_DIVZERO_FLAG_EN, DivZero pulses with Done.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A, then MFHI -> no stalls; HiLoOut=0xA5A5A5A5; Lo=0x5A5A5A5A.
- Start MULT 7*9, assert RST at iteration 10 -> next cycle Busy=0, Hi=Lo=0, Done never pulses. Re-issue MULT 7*9 -> LO=63.
